// File: rtl/bram18_readback_streamer.sv
// ---------------------------------------------------------------------------
// bram18_readback_streamer
//
// Reads a contiguous, wrapping range of x18 words (16 data + 2 parity) from
// one port of an 18Kb true-dual-port RAM. Each word's byte parity is checked
// and the word is streamed out on a valid/ready interface with backpressure.
// Used for memory dump, BIST readback and scrub flows.
//
// Parameters
//   READ_LATENCY  RAM cycles from ram_ren to valid ram_rdata (1 or 2)
//   FIFO_DEPTH    output buffer depth in words (power of two, >= READ_LATENCY+2)
//   ODD_PARITY    0 = even parity per byte, 1 = odd parity per byte
//   ADDR_LSB      bit position of word-address bit 0 inside ram_addr
//
// Ports
//   clk, reset              single clock, asynchronous active-high reset
//   start                   begin a transfer (only looked at in IDLE)
//   start_addr [9:0]        first word address
//   word_count [10:0]       number of words, 0..1024
//   abort                   cancel an active transfer
//   ram_ren, ram_addr       registered read request to the RAM port
//   ram_rdata, ram_rparity  read return; ram_rparity[i] covers byte i
//   m_tvalid/m_tready       output handshake
//   m_tdata, m_tparity      word and its stored parity
//   m_terr                  per-byte parity mismatch flags
//   m_tlast                 final word of the transfer
//   busy, done              transfer active / one-cycle completion pulse
//   err_count               words with any parity mismatch (saturating)
//
// State table
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | issuing reads as output buffer credit allows
//   DRAIN | all reads issued, waiting for the last beat to be accepted
//   FIN   | done pulse, busy already low
// ---------------------------------------------------------------------------
module bram18_readback_streamer #(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter bit ODD_PARITY   = 1'b0,
    parameter int ADDR_LSB     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  start_addr,
    input  logic [10:0] word_count,
    input  logic        abort,
    output logic        ram_ren,
    output logic [13:0] ram_addr,
    input  logic [15:0] ram_rdata,
    input  logic [1:0]  ram_rparity,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] m_tdata,
    output logic [1:0]  m_tparity,
    output logic [1:0]  m_terr,
    output logic        m_tlast,
    output logic        busy,
    output logic        done,
    output logic [10:0] err_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [10:0] ERR_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state;
    logic [9:0]  next_addr;
    logic [10:0] remaining;
    logic [9:0]  ram_word;
    logic        ram_last;

    // Read-return tracking: one valid/last bit per cycle of RAM latency.
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [READ_LATENCY-1:0] pipe_last;
    logic                    cap_vld;
    logic                    cap_last;
    logic [1:0]              exp_par;
    logic [1:0]              cap_terr;

    // Output buffer: {last, terr, parity, data}
    logic [20:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic [20:0]    head;

    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] pipe_cnt;
    logic [7:0] credit_used;
    logic       issue_ok;

    assign ram_addr = 14'(ram_word) << ADDR_LSB;

    // Abort only acts while a transfer is running; it wins over a handshake.
    assign flush = abort && ((state == ISSUE) || (state == DRAIN));

    assign cap_vld  = pipe_vld[READ_LATENCY-1];
    assign cap_last = pipe_last[READ_LATENCY-1];
    assign exp_par  = {^ram_rdata[15:8], ^ram_rdata[7:0]} ^ {2{ODD_PARITY}};
    assign cap_terr = exp_par ^ ram_rparity;

    assign head     = fifo_mem[rd_ptr];
    assign m_tvalid = (fifo_count != '0);
    assign m_tdata   = m_tvalid ? head[15:0]  : 16'h0000;
    assign m_tparity = m_tvalid ? head[17:16] : 2'b00;
    assign m_terr    = m_tvalid ? head[19:18] : 2'b00;
    assign m_tlast   = m_tvalid ? head[20]    : 1'b0;

    assign push = cap_vld && !flush;
    assign pop  = m_tvalid && m_tready && !flush;

    // Credit: words already buffered or on their way must leave room for one
    // more. A beat leaving this cycle frees its slot, which keeps the stream
    // at one word per clock when the sink never stalls.
    always_comb begin
        pipe_cnt = 8'd0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            pipe_cnt = pipe_cnt + 8'(pipe_vld[k]);
        end
        credit_used = 8'(fifo_count) + 8'(ram_ren) + pipe_cnt - 8'(pop);
        issue_ok    = (credit_used < 8'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
        end else if (flush) begin
            // In-flight returns of an aborted transfer are dropped here.
            pipe_vld  <= '0;
            pipe_last <= '0;
        end else begin
            pipe_vld[0]  <= ram_ren;
            pipe_last[0] <= ram_last;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_last[k] <= pipe_last[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cap_last, cap_terr, ram_rparity, ram_rdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            next_addr <= '0;
            remaining <= '0;
            ram_word  <= '0;
            ram_last  <= 1'b0;
            ram_ren   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
        end else begin
            ram_ren <= 1'b0;
            done    <= 1'b0;

            if (push && (cap_terr != 2'b00) && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        err_count <= '0;
                        if (word_count == 11'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            // First read goes out with the accept; buffer is empty.
                            busy      <= 1'b1;
                            ram_ren   <= 1'b1;
                            ram_word  <= start_addr;
                            ram_last  <= (word_count == 11'd1);
                            next_addr <= start_addr + 10'd1;
                            remaining <= word_count - 11'd1;
                            state     <= (word_count == 11'd1) ? DRAIN : ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (issue_ok) begin
                        ram_ren   <= 1'b1;
                        ram_word  <= next_addr;
                        ram_last  <= (remaining == 11'd1);
                        next_addr <= next_addr + 10'd1;
                        remaining <= remaining - 11'd1;
                        if (remaining == 11'd1) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pop && head[20]) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bram18_readback_streamer.md
Name: bram18_readback_streamer

Overview:
- Sequencer that reads a contiguous range of words from one x18 port of a TDP_RAM18KX2 RAM (16 data bits plus 2 parity bits).
- Checks byte parity on each word and streams the words out on a valid/ready interface with backpressure.
- Sits on the read side of an 18Kb RAM for memory dump, BIST readback and scrub flows.
- Its mirror is the INIT/WDATA load path.

Parameters:
READ_LATENCY, 1, RAM read latency in cycles from RAM_REN to RAM_RDATA valid; legal values 1 or 2.
FIFO_DEPTH, 4, output buffer depth in words; power of two, at least READ_LATENCY+2.
ODD_PARITY, 0, 0 = even parity per byte, 1 = odd parity per byte.
ADDR_LSB, 4, position of word-address bit 0 within RAM_ADDR for x18 mode.

Ports:
CLK  in  1  single clock.
RESET  in  1  asynchronous, active-high reset.
START  in  1  starts a transfer; sampled only when BUSY=0.
START_ADDR  in  10  first word address.
WORD_COUNT  in  11  number of words, 0..1024.
ABORT  in  1  cancels the active transfer.
RAM_REN  out  1  read enable to the RAM port.
RAM_ADDR  out  14  RAM address; word address at [ADDR_LSB+9:ADDR_LSB], all other bits 0.
RAM_RDATA  in  16  read data from the RAM.
RAM_RPARITY  in  2  read parity from the RAM; bit i covers RAM_RDATA[8i+7:8i].
M_TVALID  out  1  output beat valid.
M_TREADY  in  1  downstream ready.
M_TDATA  out  16  output data.
M_TPARITY  out  2  stored parity, passed through.
M_TERR  out  2  per-byte parity mismatch flags.
M_TLAST  out  1  marks the final word of the transfer.
BUSY  out  1  transfer active.
DONE  out  1  one-cycle completion pulse.
ERR_COUNT  out  11  number of words with any parity mismatch.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, FIFO empty, pipeline valids cleared, counters cleared.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE, START=1, WORD_COUNT>0: latch START_ADDR and WORD_COUNT, clear ERR_COUNT, BUSY=1, go to ISSUE.
- IDLE, START=1, WORD_COUNT=0: go to FIN with no RAM access. DONE pulses in the following cycle. ERR_COUNT is cleared.
- START while BUSY=1 is ignored.
- ISSUE:
  - Issue a read (RAM_REN=1, RAM_ADDR=current address) only when inflight + fifo_count < FIFO_DEPTH.
  - inflight = number of reads issued whose data has not yet been captured (at most READ_LATENCY).
  - After each issue: address increments modulo 1024 (1023 wraps to 0), remaining count decrements.
  - When the last read is issued, go to DRAIN.
  - RAM_REN and RAM_ADDR are registered. RAM_REN=0 otherwise; RAM_ADDR holds its last value.
- Timing:
  - First RAM_REN is asserted in the cycle after START is accepted.
  - Data for a read issued in cycle t is sampled at the end of cycle t+READ_LATENCY and pushed into the FIFO.
  - M_TVALID can rise in cycle t+READ_LATENCY+1.
  - START-to-first-M_TVALID is 2+READ_LATENCY cycles.
  - Sustained throughput is 1 word/cycle when M_TREADY=1.
- Parity check:
  - exp[i] = ^RAM_RDATA[8i+7:8i] XOR ODD_PARITY.
  - M_TERR[i] = exp[i] XOR RAM_RPARITY[i], computed at capture and stored with the word.
- ERR_COUNT increments once per captured word with M_TERR != 0. It saturates at 2047 and holds its value after the transfer.
- Output stream:
  - M_TDATA, M_TPARITY, M_TERR and M_TLAST are stable while M_TVALID=1 and M_TREADY=0.
  - M_TLAST=1 on exactly the WORD_COUNT-th beat.
  - Beat order equals address order.
- Credit rule: the FIFO never overflows. Captured data is never dropped under any M_TREADY pattern.
- DRAIN: when the beat with M_TLAST completes its handshake (M_TVALID & M_TREADY), go to FIN.
- FIN: DONE=1 for one cycle, BUSY=0 in that same cycle, then go to IDLE.
- ABORT=1 in ISSUE or DRAIN:
  - Next cycle: IDLE, BUSY=0, RAM_REN=0, M_TVALID=0.
  - FIFO is flushed and in-flight returns are discarded.
  - DONE is not pulsed. ERR_COUNT holds.
- ABORT in IDLE or FIN has no effect. ABORT has priority over a simultaneous handshake.
- RESET asserted mid-transfer: outputs go to 0 immediately (asynchronous). No partial beat is emitted after release.

Test Plan:
- READ_LATENCY=1, START_ADDR=0x010, WORD_COUNT=4, RAM returns data=addr with correct even parity, M_TREADY=1 -> RAM_REN in cycles 1-4 with addresses 0x010-0x013 (RAM_ADDR=0x0100..0x0130); M_TVALID in cycles 3-6; TDATA 0x0010..0x0013; M_TLAST in cycle 6; DONE in cycle 7; ERR_COUNT=0.
- START_ADDR=1022, WORD_COUNT=4 -> read addresses 1022, 1023, 0, 1; 4 beats; M_TLAST on the beat for address 1.
- WORD_COUNT=16, M_TREADY toggling 1-in-3, FIFO_DEPTH=4 -> all 16 words in order, no loss or duplication; occupancy never exceeds 4; output held stable while stalled.
- Bad parity on the 2nd and 5th words of 8, with bit 1 bad on the 5th -> M_TERR=01 on beat 2 and M_TERR=10 on beat 5; ERR_COUNT=2.
- ABORT asserted 3 cycles into a 32-word read with M_TREADY=0 -> next cycle BUSY=0, M_TVALID=0, RAM_REN=0, no DONE; a new START then streams cleanly from its own START_ADDR.
- WORD_COUNT=0 -> no RAM_REN, DONE pulse after 1 cycle. RESET pulse mid-transfer -> all outputs 0, FSM in IDLE.
